// File: rtl/mem_arb.sv
`timescale 1ns/1ps
// mem_arb
//   Arbitrates an instruction-fetch port (IFU) and a load/store port (LSU)
//   onto a single memory port. Only one transaction is outstanding at a time.
//   The memory request is presented while in ISSUE. The response comes back
//   one cycle after memory rvalid, or one cycle after the timeout expires.
//
//   state | meaning
//   IDLE  | no transaction; the next request picks the owner
//   ISSUE | o_mem_* presented for the owner; waiting for i_mem_gnt
//   WAIT  | accepted by memory; waiting for i_mem_rvalid or timeout
//
// Parameters
//   TO_CYCLES : 1..255, WAIT cycles without rvalid before an error response
//
// Ports
//   i_clk, i_rst (async, active-low)
//   IFU : i_ifu_req, i_ifu_addr, o_ifu_gnt, o_ifu_rvalid
//   LSU : i_lsu_req, i_lsu_wen, i_lsu_addr, i_lsu_wdata, i_lsu_wmask,
//         o_lsu_gnt, o_lsu_rvalid
//   shared response : o_rdata, o_err
//   memory : o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask,
//            i_mem_gnt, i_mem_rvalid, i_mem_rdata
//
// Build option
//   MEM_ARB_RR_EN : when defined, simultaneous requests seen in IDLE go
//                   round-robin. The requester not served last wins, and
//                   LSU wins the first tie after reset. When undefined, LSU
//                   always has priority.
module mem_arb #(
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ifu_req,
    input  logic [31:0] i_ifu_addr,
    output logic        o_ifu_gnt,
    output logic        o_ifu_rvalid,
    input  logic        i_lsu_req,
    input  logic        i_lsu_wen,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_lsu_wdata,
    input  logic [3:0]  i_lsu_wmask,
    output logic        o_lsu_gnt,
    output logic        o_lsu_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_mem_req,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wmask,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TO_CYCLES);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;          // 1 = LSU owns the transaction
    logic [7:0]  cnt_q, cnt_d;
    logic        ifu_rvalid_q, ifu_rvalid_d;
    logic        lsu_rvalid_q, lsu_rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        pick_lsu;
    logic        issue;

`ifdef MEM_ARB_RR_EN
    logic        last_lsu_q, last_lsu_d;

    // On a tie, serve whichever side was not served last.
    assign pick_lsu = i_lsu_req && (!i_ifu_req || !last_lsu_q);
`else
    assign pick_lsu = i_lsu_req;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        ifu_rvalid_d = 1'b0;
        lsu_rvalid_d = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
`ifdef MEM_ARB_RR_EN
        last_lsu_d   = last_lsu_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_ifu_req || i_lsu_req) begin
                    owner_d = pick_lsu;
                    state_d = ST_ISSUE;
`ifdef MEM_ARB_RR_EN
                    last_lsu_d = pick_lsu;
`endif
                end
            end
            ST_ISSUE: begin
                if (i_mem_gnt) begin
                    cnt_d = 8'd0;
                    if (i_mem_rvalid) begin
                        // Accepted and answered in the same cycle.
                        ifu_rvalid_d = !owner_q;
                        lsu_rvalid_d = owner_q;
                        rdata_d      = i_mem_rdata;
                        err_d        = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (i_mem_rvalid) begin
                    ifu_rvalid_d = !owner_q;
                    lsu_rvalid_d = owner_q;
                    rdata_d      = i_mem_rdata;
                    err_d        = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TO_LIMIT) begin
                        ifu_rvalid_d = !owner_q;
                        lsu_rvalid_d = owner_q;
                        rdata_d      = 32'd0;
                        err_d        = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            cnt_q        <= 8'd0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_lsu_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            ifu_rvalid_q <= ifu_rvalid_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
`ifdef MEM_ARB_RR_EN
            last_lsu_q   <= last_lsu_d;
`endif
        end
    end

    // The memory port is driven straight from the owner's held request
    // inputs. Outside ISSUE it is forced to zero, so reset clears it at once.
    assign issue       = (state_q == ST_ISSUE);
    assign o_mem_req   = issue;
    assign o_mem_wen   = issue && owner_q && i_lsu_wen;
    assign o_mem_addr  = !issue ? 32'd0 : (owner_q ? i_lsu_addr : i_ifu_addr);
    assign o_mem_wdata = (issue && owner_q) ? i_lsu_wdata : 32'd0;
    assign o_mem_wmask = (issue && owner_q) ? i_lsu_wmask : 4'd0;

    assign o_ifu_gnt    = issue && !owner_q && i_mem_gnt;
    assign o_lsu_gnt    = issue && owner_q && i_mem_gnt;
    assign o_ifu_rvalid = ifu_rvalid_q;
    assign o_lsu_rvalid = lsu_rvalid_q;
    assign o_rdata      = rdata_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_mem_arb.sv
`timescale 1ns/1ps
// Testbench for mem_arb: directed scenarios with literal expectations,
// followed by randomized requesters/memory checked every cycle against a
// transaction-level reference model.
module tb_mem_arb;
    localparam int TO = 4;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_ON = 1'b1;
`else
    localparam bit RR_ON = 1'b0;
`endif

    logic        i_clk, i_rst;
    logic        i_ifu_req;
    logic [31:0] i_ifu_addr;
    logic        o_ifu_gnt, o_ifu_rvalid;
    logic        i_lsu_req, i_lsu_wen;
    logic [31:0] i_lsu_addr, i_lsu_wdata;
    logic [3:0]  i_lsu_wmask;
    logic        o_lsu_gnt, o_lsu_rvalid;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_mem_req, o_mem_wen;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_gnt, i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arb #(.TO_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_ifu_req(i_ifu_req), .i_ifu_addr(i_ifu_addr),
        .o_ifu_gnt(o_ifu_gnt), .o_ifu_rvalid(o_ifu_rvalid),
        .i_lsu_req(i_lsu_req), .i_lsu_wen(i_lsu_wen), .i_lsu_addr(i_lsu_addr),
        .i_lsu_wdata(i_lsu_wdata), .i_lsu_wmask(i_lsu_wmask),
        .o_lsu_gnt(o_lsu_gnt), .o_lsu_rvalid(o_lsu_rvalid),
        .o_rdata(o_rdata), .o_err(o_err),
        .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one transaction record) ----------------
    bit          m_txn = 1'b0;   // a transaction is owned
    bit          m_acc = 1'b0;   // memory has accepted it
    bit          m_own = 1'b0;   // 1 = LSU
    int          m_wait = 0;     // WAIT cycles elapsed without data
    bit          m_ifu_rv = 1'b0, m_lsu_rv = 1'b0, m_err = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    logic        m_pick;
`ifdef MEM_ARB_RR_EN
    bit          m_last = 1'b0;
    assign m_pick = i_lsu_req && (!i_ifu_req || !m_last);
`else
    assign m_pick = i_lsu_req;
`endif

    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            m_txn <= 1'b0; m_acc <= 1'b0; m_own <= 1'b0; m_wait <= 0;
            m_ifu_rv <= 1'b0; m_lsu_rv <= 1'b0; m_err <= 1'b0; m_rdata <= 32'd0;
`ifdef MEM_ARB_RR_EN
            m_last <= 1'b0;
`endif
        end else begin
            m_ifu_rv <= 1'b0;
            m_lsu_rv <= 1'b0;
            if (!m_txn) begin
                if (i_ifu_req || i_lsu_req) begin
                    m_txn <= 1'b1; m_acc <= 1'b0; m_own <= m_pick;
`ifdef MEM_ARB_RR_EN
                    m_last <= m_pick;
`endif
                end
            end else if (!m_acc) begin
                if (i_mem_gnt) begin
                    m_wait <= 0;
                    if (i_mem_rvalid) begin
                        m_txn <= 1'b0; m_ifu_rv <= !m_own; m_lsu_rv <= m_own;
                        m_rdata <= i_mem_rdata; m_err <= 1'b0;
                    end else begin
                        m_acc <= 1'b1;
                    end
                end
            end else begin
                if (i_mem_rvalid) begin
                    m_txn <= 1'b0; m_acc <= 1'b0; m_ifu_rv <= !m_own; m_lsu_rv <= m_own;
                    m_rdata <= i_mem_rdata; m_err <= 1'b0;
                end else if (m_wait + 1 >= TO) begin
                    m_txn <= 1'b0; m_acc <= 1'b0; m_ifu_rv <= !m_own; m_lsu_rv <= m_own;
                    m_rdata <= 32'd0; m_err <= 1'b1;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end
        end
    end

    logic        e_req, e_wen, e_ifu_gnt, e_lsu_gnt;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wmask;
    assign e_req     = m_txn && !m_acc;
    assign e_addr    = e_req ? (m_own ? i_lsu_addr : i_ifu_addr) : 32'd0;
    assign e_wen     = e_req && m_own && i_lsu_wen;
    assign e_wdata   = (e_req && m_own) ? i_lsu_wdata : 32'd0;
    assign e_wmask   = (e_req && m_own) ? i_lsu_wmask : 4'd0;
    assign e_ifu_gnt = e_req && !m_own && i_mem_gnt;
    assign e_lsu_gnt = e_req && m_own && i_mem_gnt;

    always @(negedge i_clk) begin
        chk1 ("mdl_mem_req",    o_mem_req,    e_req);
        chk1 ("mdl_mem_wen",    o_mem_wen,    e_wen);
        chk32("mdl_mem_addr",   o_mem_addr,   e_addr);
        chk32("mdl_mem_wdata",  o_mem_wdata,  e_wdata);
        chk32("mdl_mem_wmask",  32'(o_mem_wmask), 32'(e_wmask));
        chk1 ("mdl_ifu_gnt",    o_ifu_gnt,    e_ifu_gnt);
        chk1 ("mdl_lsu_gnt",    o_lsu_gnt,    e_lsu_gnt);
        chk1 ("mdl_ifu_rvalid", o_ifu_rvalid, m_ifu_rv);
        chk1 ("mdl_lsu_rvalid", o_lsu_rvalid, m_lsu_rv);
        chk32("mdl_rdata",      o_rdata,      m_rdata);
        chk1 ("mdl_err",        o_err,        m_err);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge i_clk);
    endtask

    // Call during an ISSUE cycle: grant it, then return data on the next
    // cycle. Returns at posedge+1 of the response cycle.
    task automatic serve(input logic [31:0] d);
        logic g_i, g_l;
        i_mem_gnt = 1'b1;
        #1;
        g_i = o_ifu_gnt;
        g_l = o_lsu_gnt;
        step();
        i_mem_gnt = 1'b0;
        if (g_i) i_ifu_req = 1'b0;
        if (g_l) i_lsu_req = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = d;
        step();
        i_mem_rvalid = 1'b0;
    endtask

    logic [31:0] first_addr, second_addr;
    logic        gi, gl;
    int          rv_pct;

    initial begin
        i_rst = 1'b0; i_ifu_req = 1'b0; i_ifu_addr = 32'd0;
        i_lsu_req = 1'b0; i_lsu_wen = 1'b0; i_lsu_addr = 32'd0;
        i_lsu_wdata = 32'd0; i_lsu_wmask = 4'd0;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'd0;

        // Reset state
        at_neg();
        chk1 ("rst_mem_req", o_mem_req, 1'b0);
        chk32("rst_rdata",   o_rdata,   32'd0);
        chk1 ("rst_err",     o_err,     1'b0);
        step();
        i_rst = 1'b1;

        // IFU read with data two cycles after the grant
        step();
        i_ifu_req = 1'b1; i_ifu_addr = 32'h8000_0000;
        at_neg();
        chk1("A_idle_no_req", o_mem_req, 1'b0);
        step();
        i_mem_gnt = 1'b1;
        at_neg();
        chk1 ("A_mem_req",  o_mem_req,  1'b1);
        chk32("A_mem_addr", o_mem_addr, 32'h8000_0000);
        chk1 ("A_mem_wen",  o_mem_wen,  1'b0);
        chk1 ("A_ifu_gnt",  o_ifu_gnt,  1'b1);
        chk1 ("A_lsu_gnt",  o_lsu_gnt,  1'b0);
        step();
        i_ifu_req = 1'b0; i_mem_gnt = 1'b0;
        at_neg();
        chk1("A_ifu_gnt_pulse", o_ifu_gnt, 1'b0);
        step();
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0000_0413;
        step();
        i_mem_rvalid = 1'b0; i_mem_rdata = 32'h5555_5555;
        at_neg();
        chk1 ("A_ifu_rvalid", o_ifu_rvalid, 1'b1);
        chk1 ("A_lsu_rvalid", o_lsu_rvalid, 1'b0);
        chk32("A_rdata",      o_rdata,      32'h0000_0413);
        chk1 ("A_err",        o_err,        1'b0);
        step();
        at_neg();
        chk1 ("A_rvalid_pulse", o_ifu_rvalid, 1'b0);
        chk32("A_rdata_hold",   o_rdata,      32'h0000_0413);

        // Same-cycle IFU fetch and LSU store: LSU first
        step();
        i_ifu_req = 1'b1; i_ifu_addr = 32'h8000_0004;
        i_lsu_req = 1'b1; i_lsu_wen = 1'b1; i_lsu_addr = 32'h8000_1000;
        i_lsu_wdata = 32'hDEAD_BEEF; i_lsu_wmask = 4'hF;
        step();
        i_mem_gnt = 1'b1;
        at_neg();
        chk1 ("B_mem_wen",   o_mem_wen,   1'b1);
        chk32("B_mem_wmask", 32'(o_mem_wmask), 32'h0000_000F);
        chk32("B_mem_addr",  o_mem_addr,  32'h8000_1000);
        chk32("B_mem_wdata", o_mem_wdata, 32'hDEAD_BEEF);
        chk1 ("B_lsu_gnt",   o_lsu_gnt,   1'b1);
        chk1 ("B_ifu_gnt",   o_ifu_gnt,   1'b0);
        step();
        // LSU immediately raises a new load, so a second tie forms in IDLE.
        i_mem_gnt = 1'b0;
        i_lsu_wen = 1'b0; i_lsu_addr = 32'h8000_1004; i_lsu_wdata = 32'd0; i_lsu_wmask = 4'd0;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hA5A5_A5A5;
        step();
        i_mem_rvalid = 1'b0;
        at_neg();
        chk1 ("B_store_ack", o_lsu_rvalid, 1'b1);
        chk1 ("B_ifu_quiet", o_ifu_rvalid, 1'b0);
        chk32("B_store_rd",  o_rdata,      32'hA5A5_A5A5);
        step();
        first_addr  = RR_ON ? 32'h8000_0004 : 32'h8000_1004;
        second_addr = RR_ON ? 32'h8000_1004 : 32'h8000_0004;
        at_neg();
        chk32("B_tie2_first", o_mem_addr, first_addr);
        chk1 ("B_tie2_wen",   o_mem_wen,  1'b0);
        serve(32'h1111_0001);
        step();
        at_neg();
        chk32("B_tie2_second", o_mem_addr, second_addr);
        serve(32'h1111_0002);
        at_neg();
        chk1 ("B_second_rv_ifu", o_ifu_rvalid, RR_ON ? 1'b0 : 1'b1);
        chk32("B_second_rdata",  o_rdata,      32'h1111_0002);

        // Timeout: grant, then no data
        step();
        i_lsu_req = 1'b1; i_lsu_wen = 1'b0; i_lsu_addr = 32'h8000_2000;
        step();
        i_mem_gnt = 1'b1;
        at_neg();
        chk1("C_lsu_gnt", o_lsu_gnt, 1'b1);
        step();
        i_mem_gnt = 1'b0; i_lsu_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            at_neg();
            chk1("C_no_early_rv", o_lsu_rvalid, 1'b0);
            step();
        end
        at_neg();
        chk1 ("C_to_rvalid", o_lsu_rvalid, 1'b1);
        chk1 ("C_to_err",    o_err,        1'b1);
        chk32("C_to_rdata",  o_rdata,      32'd0);
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hFFFF_0000;
        for (int k = 0; k < 2; k++) begin
            step();
            at_neg();
            chk1 ("C_late_lsu_rv", o_lsu_rvalid, 1'b0);
            chk1 ("C_late_ifu_rv", o_ifu_rvalid, 1'b0);
            chk32("C_late_rdata",  o_rdata,      32'd0);
        end
        step();
        i_mem_rvalid = 1'b0;

        // Reset while WAIT
        i_ifu_req = 1'b1; i_ifu_addr = 32'h8000_3000;
        step();
        i_mem_gnt = 1'b1;
        step();
        i_mem_gnt = 1'b0; i_ifu_req = 1'b0;
        #2;
        i_rst = 1'b0;
        i_ifu_addr = 32'h8000_4000; i_ifu_req = 1'b1; i_mem_gnt = 1'b1;
        #1;
        chk1 ("D_rst_err",     o_err,      1'b0);
        chk1 ("D_rst_mem_req", o_mem_req,  1'b0);
        chk32("D_rst_addr",    o_mem_addr, 32'd0);
        chk1 ("D_rst_ifu_gnt", o_ifu_gnt,  1'b0);
        i_mem_gnt = 1'b0;
        step();
        step();
        i_rst = 1'b1;
        step();
        at_neg();
        chk32("D_post_addr", o_mem_addr, 32'h8000_4000);
        serve(32'hCAFE_F00D);
        at_neg();
        chk1 ("D_post_rv",  o_ifu_rvalid, 1'b1);
        chk32("D_post_rd",  o_rdata,      32'hCAFE_F00D);

        // Grant and rvalid in the same ISSUE cycle
        step();
        i_ifu_req = 1'b1; i_ifu_addr = 32'h8000_5000;
        step();
        i_mem_gnt = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1234_5678;
        #1;
        chk1("E_ifu_gnt", o_ifu_gnt, 1'b1);
        step();
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_ifu_req = 1'b0;
        i_lsu_req = 1'b1; i_lsu_wen = 1'b0; i_lsu_addr = 32'h8000_6000;
        at_neg();
        chk1 ("E_rvalid",  o_ifu_rvalid, 1'b1);
        chk32("E_rdata",   o_rdata,      32'h1234_5678);
        chk1 ("E_mem_req", o_mem_req,    1'b0);
        step();
        at_neg();
        chk32("E_idle_next", o_mem_addr, 32'h8000_6000);
        serve(32'h0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            at_neg();
            gi = o_ifu_gnt;
            gl = o_lsu_gnt;
            step();
            rv_pct = (c < 2000) ? 35 : 10;
            if (gi) i_ifu_req = 1'b0;
            if (gl) i_lsu_req = 1'b0;
            if (!i_ifu_req && $urandom_range(0, 99) < 30) begin
                i_ifu_req = 1'b1; i_ifu_addr = $urandom;
            end
            if (!i_lsu_req && $urandom_range(0, 99) < 30) begin
                i_lsu_req   = 1'b1;
                i_lsu_wen   = 1'($urandom_range(0, 1));
                i_lsu_addr  = $urandom;
                i_lsu_wdata = $urandom;
                i_lsu_wmask = 4'($urandom_range(0, 15));
            end
            i_mem_gnt    = ($urandom_range(0, 99) < 50);
            i_mem_rvalid = ($urandom_range(0, 99) < rv_pct);
            i_mem_rdata  = $urandom;
            if ($urandom_range(0, 599) == 0) begin
                i_rst = 1'b0; i_ifu_req = 1'b0; i_lsu_req = 1'b0;
            end else begin
                i_rst = 1'b1;
            end
        end

        i_ifu_req = 1'b0; i_lsu_req = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
        i_rst = 1'b1;
        repeat (3) step();
        at_neg();
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
